// File: rtl/skinny_round_ctrl_pkg.sv
// Shared encodings and helpers for the SKINNY-128-384+ round controller.
package skinny_round_ctrl_pkg;

    localparam int unsigned OP_W = 3;
    localparam int unsigned RC_W = 6;
    localparam logic [RC_W-1:0] RC_INIT = 6'h01;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD_S   = 3'd0,
        OP_LOAD_X   = 3'd1,
        OP_LOAD_Y   = 3'd2,
        OP_CNT_INIT = 3'd3,
        OP_CNT_INC  = 3'd4,
        OP_ENCRYPT  = 3'd5,
        OP_UNLOAD_S = 3'd6,
        OP_CLEAR    = 3'd7
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CNT    = 3'd2,
        ST_RUN    = 3'd3,
        ST_UNLOAD = 3'd4,
        ST_CLR    = 3'd5
    } state_e;

    // Datapath register-control bundle, one bit per control line.
    typedef struct packed {
        logic srst;
        logic senc;
        logic sse;
        logic xrst;
        logic xenc;
        logic xse;
        logic yrst;
        logic yenc;
        logic yse;
        logic zrst;
        logic zenc;
        logic zse;
        logic correct_cnt;
    } ctrl_t;

    // Round-constant LFSR step.
    function automatic logic [RC_W-1:0] rc_next(input logic [RC_W-1:0] rc);
        return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
    endfunction

endpackage

// File: rtl/skinny_rc_lfsr.sv
// Round-constant register: load to 01, step at round boundaries, clear when idle.
module skinny_rc_lfsr
    import skinny_round_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            clr,
    output logic [RC_W-1:0] rc
);

    logic [RC_W-1:0] rc_d;
    logic [RC_W-1:0] rc_q;

    // Next constant: load wins over clear, clear over step.
    always_comb begin
        rc_d = rc_q;
        if (load) begin
            rc_d = RC_INIT;
        end else if (clr) begin
            rc_d = '0;
        end else if (step) begin
            rc_d = rc_next(rc_q);
        end
    end

    // Constant register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rc_q <= '0;
        end else begin
            rc_q <= rc_d;
        end
    end

    assign rc = rc_q;

endmodule

// File: rtl/skinny_round_ctrl.sv
// Command sequencer for the masked SKINNY-128-384+ datapath.
module skinny_round_ctrl
    import skinny_round_ctrl_pkg::*;
#(
    parameter int unsigned ROUNDS    = 40,
    parameter int unsigned ROUND_LAT = 4,
    parameter int unsigned BEATS     = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [OP_W-1:0] cmd_op,
    input  logic            tk1s_in,
    input  logic [3:0]      decrypt_in,
    output logic            srst,
    output logic            senc,
    output logic            sse,
    output logic            xrst,
    output logic            xenc,
    output logic            xse,
    output logic            yrst,
    output logic            yenc,
    output logic            yse,
    output logic            zrst,
    output logic            zenc,
    output logic            zse,
    output logic            correct_cnt,
    output logic            tk1s,
    output logic [RC_W-1:0] constant,
    output logic [3:0]      decrypt,
    output logic            busy,
    output logic            done
);

    localparam int unsigned CNT_MAX = (BEATS > ROUND_LAT) ? BEATS : ROUND_LAT;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned RND_W   = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    state_e           state_q, state_d;
    cmd_op_e          op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RND_W-1:0] round_q, round_d;
    logic             tk1s_lat_q, tk1s_lat_d;
    logic [3:0]       dec_lat_q, dec_lat_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             tk1s_q, tk1s_d;
    logic [3:0]       decrypt_q, decrypt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             rc_load, rc_step, rc_clr;
    cmd_op_e          op_in;

    assign op_in = cmd_op_e'(cmd_op);

    // Next state, counters and latched command fields.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        round_d    = round_q;
        tk1s_lat_d = tk1s_lat_q;
        dec_lat_d  = dec_lat_q;
        rc_load    = 1'b0;
        rc_step    = 1'b0;
        rc_clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d       = op_in;
                    tk1s_lat_d = tk1s_in;
                    dec_lat_d  = decrypt_in;
                    cnt_d      = '0;
                    round_d    = '0;
                    case (op_in)
                        OP_LOAD_S, OP_LOAD_X, OP_LOAD_Y: state_d = ST_LOAD;
                        OP_CNT_INIT, OP_CNT_INC:         state_d = ST_CNT;
                        OP_ENCRYPT: begin
                            state_d = ST_RUN;
                            rc_load = 1'b1;
                        end
                        OP_UNLOAD_S:                     state_d = ST_UNLOAD;
                        OP_CLEAR:                        state_d = ST_CLR;
                        default:                         state_d = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD, ST_UNLOAD: begin
                if (cnt_q == CNT_W'(BEATS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CNT, ST_CLR: begin
                state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (cnt_q == CNT_W'(ROUND_LAT - 1)) begin
                    cnt_d = '0;
                    if (round_q == RND_W'(ROUNDS - 1)) begin
                        state_d = ST_IDLE;
                        rc_clr  = 1'b1;
                    end else begin
                        round_d = round_q + RND_W'(1);
                        rc_step = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                rc_clr  = 1'b1;
            end
        endcase
    end

    // Output decode from the upcoming state so every output is a flop.
    always_comb begin
        ctrl_d    = '0;
        tk1s_d    = 1'b0;
        decrypt_d = '0;
        busy_d    = (state_d != ST_IDLE);
        ready_d   = (state_d == ST_IDLE);
        done_d    = (state_d == ST_IDLE) && (state_q != ST_IDLE);
        case (state_d)
            ST_LOAD: begin
                case (op_d)
                    OP_LOAD_S: begin ctrl_d.sse = 1'b1; ctrl_d.senc = 1'b1; end
                    OP_LOAD_X: begin ctrl_d.xse = 1'b1; ctrl_d.xenc = 1'b1; end
                    OP_LOAD_Y: begin ctrl_d.yse = 1'b1; ctrl_d.yenc = 1'b1; end
                    default: ;
                endcase
            end
            ST_UNLOAD: begin
                ctrl_d.sse  = 1'b1;
                ctrl_d.senc = 1'b1;
                decrypt_d   = dec_lat_d;
            end
            ST_CNT: begin
                if (op_d == OP_CNT_INIT) begin
                    ctrl_d.zrst = 1'b1;
                end else begin
                    ctrl_d.zenc        = 1'b1;
                    ctrl_d.zse         = 1'b1;
                    ctrl_d.correct_cnt = 1'b1;
                end
            end
            ST_CLR: begin
                ctrl_d.srst = 1'b1;
                ctrl_d.xrst = 1'b1;
                ctrl_d.yrst = 1'b1;
                ctrl_d.zrst = 1'b1;
            end
            ST_RUN: begin
                tk1s_d = tk1s_lat_d;
                if (cnt_d == CNT_W'(ROUND_LAT - 1)) begin
                    ctrl_d.senc = 1'b1;
                    ctrl_d.xenc = 1'b1;
                    ctrl_d.yenc = 1'b1;
                    ctrl_d.zenc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_LOAD_S;
            cnt_q      <= '0;
            round_q    <= '0;
            tk1s_lat_q <= 1'b0;
            dec_lat_q  <= '0;
            ctrl_q     <= '0;
            tk1s_q     <= 1'b0;
            decrypt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            round_q    <= round_d;
            tk1s_lat_q <= tk1s_lat_d;
            dec_lat_q  <= dec_lat_d;
            ctrl_q     <= ctrl_d;
            tk1s_q     <= tk1s_d;
            decrypt_q  <= decrypt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    skinny_rc_lfsr u_rc_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (rc_load),
        .step (rc_step),
        .clr  (rc_clr),
        .rc   (constant)
    );

    assign srst        = ctrl_q.srst;
    assign senc        = ctrl_q.senc;
    assign sse         = ctrl_q.sse;
    assign xrst        = ctrl_q.xrst;
    assign xenc        = ctrl_q.xenc;
    assign xse         = ctrl_q.xse;
    assign yrst        = ctrl_q.yrst;
    assign yenc        = ctrl_q.yenc;
    assign yse         = ctrl_q.yse;
    assign zrst        = ctrl_q.zrst;
    assign zenc        = ctrl_q.zenc;
    assign zse         = ctrl_q.zse;
    assign correct_cnt = ctrl_q.correct_cnt;
    assign tk1s        = tk1s_q;
    assign decrypt     = decrypt_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cmd_ready   = ready_q;

endmodule

// File: doc/skinny_round_ctrl.md
SKINNY_ROUND_CTRL -- requirements
Module: skinny_round_ctrl

Interface
REQ-001 Parameter ROUNDS, default 40: SKINNY-128-384+ rounds per ENCRYPT.
REQ-002 Parameter ROUND_LAT, default 4: cycles per round of the masked (HPC2, d=3) round function; legal range 1..15.
REQ-003 Parameter BEATS, default 4: 32-bit beats per 128-bit share-register load or unload.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid / cmd_ready  in / out  1 / 1  command handshake; a command is accepted when both are 1 on a clock edge.
REQ-007 cmd_op  in  3  opcode: 0 LOAD_S, 1 LOAD_X, 2 LOAD_Y, 3 CNT_INIT, 4 CNT_INC, 5 ENCRYPT, 6 UNLOAD_S, 7 CLEAR.
REQ-008 tk1s_in  in  1  counter-in-TK1 select; sampled at accept.
REQ-009 decrypt_in  in  4  per-byte decrypt mask; sampled at accept.
REQ-010 srst, senc, sse, xrst, xenc, xse, yrst, yenc, yse, zrst, zenc, zse  out  1 each  datapath register controls.
REQ-011 correct_cnt  out  1  counter-correction select.
REQ-012 tk1s  out  1  counter-in-TK1 enable.
REQ-013 constant  out  6  round constant.
REQ-014 decrypt  out  4  registered copy of decrypt_in.
REQ-015 busy / done  out  1 / 1  operation in progress / one-cycle completion pulse.

Function
REQ-016 FSM states: IDLE, LOAD, CNT, RUN, UNLOAD, CLR.
REQ-017 cmd_ready SHALL be 1 only in IDLE; busy SHALL be 1 in every other state.
REQ-018 LOAD_S/X/Y SHALL enter LOAD and hold {sse,senc}, {xse,xenc} or {yse,yenc} respectively at 1 for exactly BEATS cycles.
REQ-019 UNLOAD_S SHALL hold sse=senc=1 for BEATS cycles with decrypt driven from the value latched at accept; at all other times decrypt SHALL be 0.
REQ-020 CNT_INIT SHALL assert zrst for 1 cycle.
REQ-021 CNT_INC SHALL assert zenc=zse=correct_cnt=1 for 1 cycle.
REQ-022 CLEAR SHALL assert srst, xrst, yrst and zrst together for 1 cycle.
REQ-023 ENCRYPT SHALL enter RUN for exactly ROUNDS*ROUND_LAT cycles, tracked by a round counter (0..ROUNDS-1) and a phase counter (0..ROUND_LAT-1).
REQ-024 RUN: senc, xenc, yenc and zenc SHALL be 1 only in the phase-(ROUND_LAT-1) cycle of each round, with sse=xse=yse=zse=0.
REQ-025 RUN: tk1s SHALL equal the latched tk1s_in; outside RUN, tk1s SHALL be 0.
REQ-026 constant SHALL be 6'h01 in round 0 and SHALL be held for the whole round.
REQ-027 At each round boundary, constant SHALL update as next = {rc[4:0], rc[5]^rc[4]^1}.
REQ-028 Outside RUN, constant SHALL be 0.
REQ-029 done SHALL pulse for 1 cycle in the first IDLE cycle after any operation; a new command SHALL be acceptable in that same cycle.
REQ-030 At most one datapath control group SHALL be active in any cycle; all controls SHALL be 0 in IDLE.
REQ-031 A cmd_valid arriving while busy SHALL be ignored, not queued; the requester holds it until cmd_ready.
REQ-032 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-033 Asserting rst SHALL force IDLE and zero both counters, constant, decrypt, done and every register-control output.
REQ-034 After rst deasserts, cmd_ready SHALL be 1 on the first clock.
REQ-035 Reset mid-RUN or mid-LOAD SHALL abort the operation without a done pulse.

Structure
REQ-036 The opcode encoding, FSM state encoding and the round-constant update function SHALL live in the shared Romulus package.
REQ-037 The round-constant LFSR SHALL be one sub-module, skinny_rc_lfsr, with load-to-01 and step inputs.

Verification
REQ-038 Reset then CLEAR -> srst=xrst=yrst=zrst=1 for exactly 1 cycle, done on the next cycle, cmd_ready=1.
REQ-039 LOAD_X with BEATS=4 -> xse=xenc=1 for 4 consecutive cycles, all other controls 0, busy=1 for those 4 cycles.
REQ-040 ENCRYPT with ROUND_LAT=4, tk1s_in=1 -> constant sequence 01,03,07,0F,1F,3E,3D each held 4 cycles; senc pulses at cycles 3,7,11,...; 40 senc pulses total; done at cycle 160; tk1s=1 throughout RUN.
REQ-041 CNT_INC -> zenc=zse=correct_cnt=1 for 1 cycle; a back-to-back ENCRYPT accepted on the done cycle starts RUN the next cycle.
REQ-042 rst asserted at round 17 of ENCRYPT -> all outputs 0 immediately, no done; a following ENCRYPT starts again at constant 01.
REQ-043 cmd_valid pulsed during RUN with cmd_op=7 -> no srst/xrst/yrst/zrst during RUN; RUN length unchanged.
